bram_wnd_rd: RTL and testbench
==============================

// Module: bram_wnd_rd
// PURPOSE
//  Read side of the 8-line grey-pixel ring BRAM filled by the pixel converter.
//  Waits for wnd_in_bram, then walks the ring one column at a time, assembling
//  a 3x3 window of 8-bit grey pixels for the downstream filter (valid/ready).
//  Pulses pixel_ack once per finished output row, freeing the oldest line so
//  the writer can fetch the next AXI burst.
// PARAMETERS
//  HRES    640  pixels per line
//  VRES    480  lines per frame
//  NLINES  8    lines held in the BRAM ring (ring size NLINES*HRES words)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  wnd_in_bram  in   1   writer flag: at least NLINES lines resident
//  bram_rd_en   out  1   BRAM read strobe, port B
//  bram_addr    out  13  BRAM word address, 0..NLINES*HRES-1
//  bram_data    in   16  BRAM read data, grey value in [7:0]; 1-cycle latency
//  wnd_data     out  72  3x3 window; [71:64]=top-left ... [7:0]=bottom-right, row-major
//  wnd_valid    out  1   window valid; held with data until accepted
//  wnd_ready    in   1   downstream accept
//  wnd_col      out  12  centre column of current window (1..HRES-2)
//  wnd_row      out  12  centre row of current window (1..VRES-2)
//  pixel_ack    out  1   1-cycle pulse per completed output row
//  frame_done   out  1   1-cycle pulse after last window of frame accepted
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; col=0; row=1; line bases top/mid/bot=0/1/2.
//  Line base addresses kept as running sums (+HRES, wrap at NLINES*HRES -> 0);
//   no multiplier. addr = base + col, 13-bit, never exceeds NLINES*HRES-1.
//  FSM:
//   IDLE  : wait for wnd_in_bram=1 (sampled only here) -> RD.
//   RD    : 3 cycles, bram_rd_en=1, addr = top+col, mid+col, bot+col in order.
//   CAP   : 1 cycle; data for read k captured the cycle after it was issued;
//           window shifts left one column, new column enters at right.
//           col<2 -> col++, RD.  col>=2 -> OUT.
//   OUT   : wnd_valid=1, wnd_data/col/row stable until wnd_ready=1.
//           On accept: col==HRES-1 -> ROW; else col++, RD.
//   ROW   : pixel_ack=1 for exactly 1 cycle; col=0; top/mid/bot each +HRES
//           (wrap); row++. row was VRES-2 -> frame_done pulse, reset row=1,
//           bases to 0/1/2 line offset continuation (bases keep rolling), IDLE.
//           Else -> IDLE (re-check wnd_in_bram before each row).
//  Throughput: 5 cycles/window with wnd_ready held high; first window of a row
//   appears 12 cycles after leaving IDLE.
//  Windows per row = HRES-2 (cols 0,1 prime only); rows per frame = VRES-2.
//  wnd_ready high outside OUT is ignored; wnd_valid never drops without accept.
//  Simultaneous accept and last column: ROW entered next cycle, no extra window.
//  wnd_in_bram falling mid-row: ignored until row finishes.
//  rst mid-operation: immediate return to reset state, any pending window lost,
//   no pixel_ack/frame_done emitted.
//  wnd_col = col-1, wnd_row = row at time of OUT.
// TESTING (bench params HRES=8, VRES=6, NLINES=4; BRAM model word[a]=a[7:0])
//  1 Reset: rst 3 cycles -> all outputs 0; wnd_in_bram=0 -> no bram_rd_en ever.
//  2 First row: wnd_in_bram=1, ready=1 -> addrs 0,8,16,1,9,17,...; 6 windows,
//    first wnd_data centre byte=9 (addr 9), wnd_col=1, wnd_row=1; then one pixel_ack.
//  3 Backpressure: wnd_ready=0 for 10 cycles during OUT -> wnd_valid/data stable,
//    no new bram_rd_en, window count unchanged after release.
//  4 Ring wrap: rows 1..4 -> bottom line of row 3 reads addr 0..7 again
//    (base wrapped 32->0); centre bytes match model modulo wrap.
//  5 Frame end: full frame -> 24 windows, 4 pixel_ack pulses, 1 frame_done
//    in cycle after last ROW, FSM back to IDLE.
//  6 Reset mid-row after 3 windows -> outputs 0, next run restarts at addr 0,8,16.

Source files
------------

// File: rtl/bram_wnd_rd.sv
// Read side of the grey-pixel line ring: walks the ring column by column and
// presents a 3x3 window per centre pixel with valid/ready, acking each finished row.
module bram_wnd_rd #(
  parameter int HRES   = 640,
  parameter int VRES   = 480,
  parameter int NLINES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wnd_in_bram,
  output logic        bram_rd_en,
  output logic [12:0] bram_addr,
  input  logic [15:0] bram_data,
  output logic [71:0] wnd_data,
  output logic        wnd_valid,
  input  logic        wnd_ready,
  output logic [11:0] wnd_col,
  output logic [11:0] wnd_row,
  output logic        pixel_ack,
  output logic        frame_done,
  output logic [2:0]  dbg_state
);

  localparam int RING = NLINES * HRES;

  // Handshake: wnd_valid rises in OUT and holds wnd_data/wnd_col/wnd_row
  // unchanged until a cycle with wnd_valid && wnd_ready; that cycle is the transfer.
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_OUT, S_ROW} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             rd_idx;
  logic [11:0]            col, row;
  logic [12:0]            base_top, base_mid, base_bot;
  logic [12:0]            base_sel;
  logic [7:0]             nc0, nc1;
  logic [2:0][2:0][7:0]   win;
  logic                   unused_hi;

  assign unused_hi = ^bram_data[15:8];
  assign dbg_state = state;

  // Line bases advance by one line and wrap at the ring end, so no multiplier is needed.
  function automatic logic [12:0] wrap_add(input logic [12:0] b);
    logic [13:0] s;
    s = {1'b0, b} + 14'(HRES);
    if (s >= 14'(RING)) return '0;
    return s[12:0];
  endfunction

  always_comb begin
    case (rd_idx)
      2'd0:    base_sel = base_top;
      2'd1:    base_sel = base_mid;
      default: base_sel = base_bot;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    bram_rd_en = 1'b0;
    bram_addr  = '0;
    wnd_valid  = 1'b0;
    wnd_col    = '0;
    wnd_row    = '0;
    pixel_ack  = 1'b0;
    case (state)
      S_IDLE: if (wnd_in_bram) state_nxt = S_RD;
      S_RD: begin
        bram_rd_en = 1'b1;
        bram_addr  = base_sel + 13'(col);
        if (rd_idx == 2'd2) state_nxt = S_CAP;
      end
      S_CAP: state_nxt = (col >= 12'd2) ? S_OUT : S_RD;
      S_OUT: begin
        wnd_valid = 1'b1;
        wnd_col   = col - 12'd1;
        wnd_row   = row;
        if (wnd_ready) state_nxt = (col == 12'(HRES - 1)) ? S_ROW : S_RD;
      end
      S_ROW: begin
        pixel_ack = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_idx     <= '0;
      col        <= '0;
      row        <= 12'd1;
      base_top   <= '0;
      base_mid   <= 13'(HRES);
      base_bot   <= 13'(2 * HRES);
      nc0        <= '0;
      nc1        <= '0;
      win        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= 1'b0;
      case (state)
        S_RD: begin
          // Read data arrives one cycle after its strobe.
          rd_idx <= (rd_idx == 2'd2) ? 2'd0 : rd_idx + 2'd1;
          if (rd_idx == 2'd1) nc0 <= bram_data[7:0];
          if (rd_idx == 2'd2) nc1 <= bram_data[7:0];
        end
        S_CAP: begin
          for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
          end
          win[0][2] <= nc0;
          win[1][2] <= nc1;
          win[2][2] <= bram_data[7:0];
          if (col < 12'd2) col <= col + 12'd1;
        end
        S_OUT: begin
          if (wnd_ready && col != 12'(HRES - 1)) col <= col + 12'd1;
        end
        S_ROW: begin
          col      <= '0;
          base_top <= wrap_add(base_top);
          base_mid <= wrap_add(base_mid);
          base_bot <= wrap_add(base_bot);
          if (row == 12'(VRES - 2)) begin
            row        <= 12'd1;
            frame_done <= 1'b1;
          end else begin
            row <= row + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wnd_data = {win[0][0], win[0][1], win[0][2],
                     win[1][0], win[1][1], win[1][2],
                     win[2][0], win[2][1], win[2][2]};

endmodule

// File: tb/tb_bram_wnd_rd.sv
// Bench for bram_wnd_rd: small ring (8x6 frame, 4 lines), BRAM word[a]=a[7:0],
// scoreboard model derived from line/column arithmetic.
module tb_bram_wnd_rd;
  localparam int HRES   = 8;
  localparam int VRES   = 6;
  localparam int NLINES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wnd_in_bram = 1'b0;
  logic        bram_rd_en;
  logic [12:0] bram_addr;
  logic [15:0] bram_data = '0;
  logic [71:0] wnd_data;
  logic        wnd_valid;
  logic        wnd_ready = 1'b0;
  logic [11:0] wnd_col, wnd_row;
  logic        pixel_ack, frame_done;
  logic [2:0]  dbg_state;

  bram_wnd_rd #(.HRES(HRES), .VRES(VRES), .NLINES(NLINES)) dut (
    .clk(clk), .rst(rst), .wnd_in_bram(wnd_in_bram),
    .bram_rd_en(bram_rd_en), .bram_addr(bram_addr), .bram_data(bram_data),
    .wnd_data(wnd_data), .wnd_valid(wnd_valid), .wnd_ready(wnd_ready),
    .wnd_col(wnd_col), .wnd_row(wnd_row), .pixel_ack(pixel_ack),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // BRAM model: one-cycle read latency, random junk in the upper byte
  always @(posedge clk) begin
    if (bram_rd_en) bram_data <= {8'($urandom_range(0, 255)), bram_addr[7:0]};
  end

  int tests = 0;
  int errors = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // reference model: line n of the stream lives at ring line n mod NLINES
  function automatic int line_base(input int n);
    return (n % NLINES) * HRES;
  endfunction

  function automatic logic [12:0] exp_addr(input int g, input int k);
    return 13'(line_base(g + k % 3) + k / 3);
  endfunction

  function automatic logic [71:0] exp_win(input int g, input int x);
    logic [71:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[71 - 8 * (dr * 3 + dc) -: 8] = 8'((line_base(g + dr) + x - 1 + dc) & 255);
    return w;
  endfunction

  // scoreboard state
  logic [12:0] exp_q[$];
  int g = 0, rd_seen = 0, win_seen = 0;
  int rd_total = 0, acc_total = 0, ack_cnt = 0, frame_cnt = 0;
  int cyc = 0, last_acc = 0, acc_gap = 0;
  logic have_prev = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [71:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      g = 0; rd_seen = 0; win_seen = 0; have_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (have_prev && prev_valid && !prev_ready) begin
        check("hold_valid", 72'(wnd_valid), 72'(1));
        check("hold_data", wnd_data, prev_data);
      end
      if (bram_rd_en) begin
        if (exp_q.size() == 0)
          for (int k = 0; k < 3 * HRES; k++) exp_q.push_back(exp_addr(g, k));
        check("addr", 72'(bram_addr), 72'(exp_q.pop_front()));
        rd_seen++; rd_total++;
      end
      if (wnd_valid && wnd_ready) begin
        check("win_data", wnd_data, exp_win(g, win_seen + 1));
        check("win_col", 72'(wnd_col), 72'(win_seen + 1));
        check("win_row", 72'(wnd_row), 72'((g % (VRES - 2)) + 1));
        if (win_seen > 0) acc_gap = cyc - last_acc;
        last_acc = cyc;
        win_seen++; acc_total++;
      end
      if (pixel_ack) begin
        check("row_reads", 72'(rd_seen), 72'(3 * HRES));
        check("row_wins", 72'(win_seen), 72'(HRES - 2));
        g++; rd_seen = 0; win_seen = 0; ack_cnt++;
      end
      if (frame_done) begin
        frame_cnt++;
        check("frame_pos", 72'(g % (VRES - 2)), 72'(0));
        check("frame_idle", 72'(dbg_state), 72'(0));
      end
      prev_valid = wnd_valid; prev_ready = wnd_ready; prev_data = wnd_data;
      have_prev = 1'b1;
    end
  end

  // driver tasks
  task automatic check_zero(input string name);
    check({name, "_ctl"}, 72'({bram_rd_en, bram_addr, wnd_valid, wnd_col, wnd_row,
                               pixel_ack, frame_done}), 72'(0));
    check({name, "_data"}, wnd_data, 72'(0));
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_ack"}, 72'(ack_cnt), 72'(target));
  endtask

  task automatic wait_frame(input int target, input int budget, input logic rand_mode);
    int n = 0;
    while (frame_cnt < target && n < budget) begin
      @(posedge clk); #1; n++;
      if (rand_mode) begin
        wnd_ready   = ($urandom_range(0, 3) != 0);
        wnd_in_bram = ($urandom_range(0, 1) != 0);
      end
    end
    check("frame_reached", 72'(frame_cnt), 72'(target));
  endtask

  typedef struct {
    logic        in_bram;
    logic        ready;
    logic        exp_rd_en;
    logic [12:0] exp_addr;
    logic        exp_valid;
  } vec_t;

  vec_t vec[15];

  initial begin
    int snap, acks0, frames0, n;
    logic [71:0] held;

    // in_bram drops after the first cycle: the row must continue regardless
    vec[0]  = '{0, 0, 0,  0, 0};
    vec[1]  = '{1, 0, 1,  0, 0};
    vec[2]  = '{0, 0, 1,  8, 0};
    vec[3]  = '{0, 0, 1, 16, 0};
    vec[4]  = '{0, 0, 0,  0, 0};
    vec[5]  = '{0, 0, 1,  1, 0};
    vec[6]  = '{0, 0, 1,  9, 0};
    vec[7]  = '{0, 0, 1, 17, 0};
    vec[8]  = '{0, 0, 0,  0, 0};
    vec[9]  = '{0, 0, 1,  2, 0};
    vec[10] = '{0, 0, 1, 10, 0};
    vec[11] = '{0, 0, 1, 18, 0};
    vec[12] = '{0, 0, 0,  0, 0};
    vec[13] = '{0, 0, 0,  0, 1};
    vec[14] = '{0, 0, 0,  0, 1};

    // reset, then idle with no lines resident
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_no_read", 72'(rd_total), 72'(0));
    check_zero("idle");

    // first window, cycle by cycle
    for (int i = 0; i < 15; i++) begin
      wnd_in_bram = vec[i].in_bram;
      wnd_ready   = vec[i].ready;
      @(posedge clk); #1;
      check($sformatf("vec%0d_rd_en", i), 72'(bram_rd_en), 72'(vec[i].exp_rd_en));
      check($sformatf("vec%0d_addr", i), 72'(bram_addr), 72'(vec[i].exp_addr));
      check($sformatf("vec%0d_valid", i), 72'(wnd_valid), 72'(vec[i].exp_valid));
    end
    check("first_centre", 72'(wnd_data[39:32]), 72'(9));
    check("first_col", 72'(wnd_col), 72'(1));
    check("first_row", 72'(wnd_row), 72'(1));

    // backpressure
    snap = rd_total;
    held = wnd_data;
    repeat (10) @(posedge clk);
    #1;
    check("bp_no_read", 72'(rd_total), 72'(snap));
    check("bp_valid", 72'(wnd_valid), 72'(1));
    check("bp_data", wnd_data, held);
    check("bp_wins", 72'(acc_total), 72'(0));
    wnd_ready = 1'b1;
    wait_acks(1, 200, "row1");
    check("row1_wins", 72'(acc_total), 72'(HRES - 2));

    // rest of frame 1 under random ready / in_bram (covers ring wrap at row 3)
    wait_frame(1, 5000, 1'b1);
    check("f1_acks", 72'(ack_cnt), 72'(VRES - 2));
    check("f1_wins", 72'(acc_total), 72'((VRES - 2) * (HRES - 2)));

    // frame 2 at full rate
    wnd_in_bram = 1'b1;
    wnd_ready   = 1'b1;
    wait_frame(2, 2000, 1'b0);
    check("f2_acks", 72'(ack_cnt), 72'(2 * (VRES - 2)));
    check("f2_wins", 72'(acc_total), 72'(2 * (VRES - 2) * (HRES - 2)));
    check("throughput", 72'(acc_gap), 72'(5));

    // one more row so the bases are off their start, then reset mid-row
    wait_acks(2 * (VRES - 2) + 1, 200, "pre_rst");
    n = 0;
    while (win_seen < 3 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("mid_row_wins", 72'(win_seen), 72'(3));
    acks0   = ack_cnt;
    frames0 = frame_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_no_ack", 72'(ack_cnt), 72'(acks0));
    check("rst_no_frame", 72'(frame_cnt), 72'(frames0));
    wait_acks(acks0 + 1, 200, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
